pal_macrocell_array: RTL

//  Parametrised PAL core: programmable AND plane, OR plane and per-output macrocell (comb/D/T/inverted).

---
 rtl/pal_macrocell_array.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pal_macrocell_array.sv
// PAL core: AND plane, OR plane and per-output macrocell,
// configured through a serially loaded, valid-qualified bitstream.
module pal_macrocell_array #(
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_TERMS   = 11,
  parameter int NUM_OUTPUTS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  input  logic                   cfg_data,
  input  logic                   cfg_restart,
  output logic                   cfg_done,
  output logic [$clog2(2*NUM_INPUTS*NUM_TERMS+NUM_TERMS*NUM_OUTPUTS
                       +2*NUM_OUTPUTS+1)-1:0] cfg_count,
  input  logic                   enable,
  input  logic [NUM_INPUTS-1:0]  pal_in,
  output logic [NUM_OUTPUTS-1:0] pal_out
);

  localparam int AND_LEN = 2*NUM_INPUTS*NUM_TERMS;
  localparam int OR_LEN  = NUM_TERMS*NUM_OUTPUTS;
  localparam int MC_LEN  = 2*NUM_OUTPUTS;
  localparam int CFG_LEN = AND_LEN + OR_LEN + MC_LEN;
  localparam int CW      = $clog2(CFG_LEN+1);
  localparam int RW      = 2*NUM_INPUTS;

  typedef enum logic {LOAD, DONE} state_t;

  state_t state, state_nx;

  logic [CFG_LEN-1:0]     cfg;
  logic [CW-1:0]          count;
  logic                   accept;
  logic                   last_bit;
  logic                   active;
  logic [RW-1:0]          lit;
  logic [NUM_TERMS-1:0]   term;
  logic [NUM_OUTPUTS-1:0] sum;
  logic [NUM_OUTPUTS-1:0] mc;
  logic [1:0]             mode [NUM_OUTPUTS];

  assign accept   = (state == LOAD) && cfg_valid && !cfg_restart;
  assign last_bit = (count == CW'(CFG_LEN-1));

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD: if (accept && last_bit) state_nx = DONE;
      DONE: if (cfg_restart)        state_nx = LOAD;
      default:                      state_nx = LOAD;
    endcase
  end

  always_comb begin
    cfg_done = (state == DONE);
    active   = (state == DONE) && enable;
  end

  // Right shift: after CFG_LEN accepted bits, bit k sits in cfg[k].
  always_ff @(posedge clk) begin
    if (rst || cfg_restart) begin
      cfg   <= '0;
      count <= '0;
    end else if (accept) begin
      cfg   <= {cfg_data, cfg[CFG_LEN-1:1]};
      count <= count + 1'b1;
    end
  end

  assign cfg_count = count;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      lit[2*i]   = pal_in[i];
      lit[2*i+1] = ~pal_in[i];
    end
  end

  // An empty row is forced low; i and ~i together can never match.
  for (genvar t = 0; t < NUM_TERMS; t++) begin : g_term
    logic [RW-1:0] row;
    assign row     = cfg[RW*t +: RW];
    assign term[t] = (|row) && (&(~row | lit));
  end

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
    assign sum[o]  = |(term & cfg[AND_LEN+NUM_TERMS*o +: NUM_TERMS]);
    assign mode[o] = cfg[AND_LEN+OR_LEN+2*o +: 2];
  end

  always_ff @(posedge clk) begin
    if (rst || cfg_restart) begin
      mc <= '0;
    end else if (active) begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        unique case (mode[o])
          2'b01:   mc[o] <= sum[o];
          2'b10:   mc[o] <= mc[o] ^ sum[o];
          default: mc[o] <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    pal_out = '0;
    if (active) begin
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        unique case (mode[o])
          2'b00:   pal_out[o] = sum[o];
          2'b11:   pal_out[o] = ~sum[o];
          default: pal_out[o] = mc[o];
        endcase
      end
    end
  end

endmodule
